// File: rtl/eth_mac_stats.sv
// Per-frame MAC statistics counters with an atomic snapshot into shadow registers and an addressed read port.
// Build option: define ETH_STATS_SATURATE_EN to make counters stick at all-ones instead of wrapping.
module eth_mac_stats #(
    parameter int CNT_W       = 32,
    parameter int BYTE_W      = 48,
    parameter int CLR_ON_SNAP = 1
) (
    input  logic              clk156,
    input  logic              sys_rst_n,
    input  logic [29:0]       rx_statistics_vector,
    input  logic              rx_statistics_valid,
    input  logic [25:0]       tx_statistics_vector,
    input  logic              tx_statistics_valid,
    input  logic              snap_req,
    output logic              snap_done,
    input  logic              rd_en,
    input  logic [2:0]        rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid
);

    typedef enum logic {S_IDLE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              capture;
    logic              rx_good_hit, tx_good_hit;
    logic [BYTE_W-1:0] rx_len, tx_len;
    logic [BYTE_W-1:0] inc [8];
    logic [BYTE_W-1:0] shd_ext [8];
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              vec_unused;

    assign vec_unused = ^{rx_statistics_vector[29:20], tx_statistics_vector[25:20],
                          tx_statistics_vector[4:1]};

    // Per-counter increments, indexed by read address.
    assign rx_good_hit = rx_statistics_valid & rx_statistics_vector[0];
    assign tx_good_hit = tx_statistics_valid & tx_statistics_vector[0];
    assign rx_len      = BYTE_W'(rx_statistics_vector[19:5]);
    assign tx_len      = BYTE_W'(tx_statistics_vector[19:5]);

    assign inc[0] = BYTE_W'(rx_good_hit);
    assign inc[1] = BYTE_W'(rx_statistics_valid & rx_statistics_vector[1]);
    assign inc[2] = BYTE_W'(rx_statistics_valid & rx_statistics_vector[2]);
    assign inc[3] = rx_good_hit ? rx_len : '0;
    assign inc[4] = BYTE_W'(tx_good_hit);
    assign inc[5] = tx_good_hit ? tx_len : '0;
    assign inc[6] = BYTE_W'(rx_good_hit & rx_statistics_vector[3]);
    assign inc[7] = BYTE_W'(rx_good_hit & rx_statistics_vector[4]);

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (snap_req) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        snap_done = (state_q == S_DONE);
        capture   = (state_q == S_IDLE) && snap_req;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            localparam int W = (gi == 3 || gi == 5) ? BYTE_W : CNT_W;

            logic [W-1:0] cnt_q, cnt_d, shd_q, base;
            logic [W:0]   sum;

            // A frame landing on the capture edge starts the next interval, so it is added after the clear.
            assign base = (capture && CLR_ON_SNAP != 0) ? '0 : cnt_q;
            assign sum  = {1'b0, base} + (W+1)'(inc[gi]);

`ifdef ETH_STATS_SATURATE_EN
            assign cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
            logic carry_unused;
            assign carry_unused = sum[W];
            assign cnt_d        = sum[W-1:0];
`endif

            always_ff @(posedge clk156 or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cnt_q <= '0;
                    shd_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    if (capture) begin
                        shd_q <= cnt_q;
                    end
                end
            end

            assign shd_ext[gi] = BYTE_W'(shd_q);
        end
    endgenerate

    assign rd_data_d = rd_en ? shd_ext[rd_addr] : rd_data_q;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_eth_mac_stats.sv
// Directed bench for eth_mac_stats: main instance with default widths, plus a 2-bit-counter instance for overflow.
module tb_eth_mac_stats;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic [29:0] rx_vec;
    logic        rx_valid;
    logic [25:0] tx_vec;
    logic        tx_valid;
    logic        snap_req;
    logic        snap_done;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [47:0] rd_data;
    logic        rd_valid;

    logic [29:0] s_rx_vec;
    logic        s_rx_valid;
    logic [25:0] s_tx_vec;
    logic        s_tx_valid;
    logic        s_snap_req;
    logic        s_snap_done;
    logic        s_rd_en;
    logic [2:0]  s_rd_addr;
    logic [47:0] s_rd_data;
    logic        s_rd_valid;

    int n_pass  = 0;
    int n_total = 0;

    always #3 clk156 = ~clk156;

    eth_mac_stats u_dut (
        .clk156               (clk156),
        .sys_rst_n            (sys_rst_n),
        .rx_statistics_vector (rx_vec),
        .rx_statistics_valid  (rx_valid),
        .tx_statistics_vector (tx_vec),
        .tx_statistics_valid  (tx_valid),
        .snap_req             (snap_req),
        .snap_done            (snap_done),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid)
    );

    // Narrow frame counters so the overflow boundary is reachable in a few frames.
    eth_mac_stats #(.CNT_W(2)) u_sat (
        .clk156               (clk156),
        .sys_rst_n            (sys_rst_n),
        .rx_statistics_vector (s_rx_vec),
        .rx_statistics_valid  (s_rx_valid),
        .tx_statistics_vector (s_tx_vec),
        .tx_statistics_valid  (s_tx_valid),
        .snap_req             (s_snap_req),
        .snap_done            (s_snap_done),
        .rd_en                (s_rd_en),
        .rd_addr              (s_rd_addr),
        .rd_data              (s_rd_data),
        .rd_valid             (s_rd_valid)
    );

    // All helpers are entered and left just after a falling edge.
    task automatic rx_pulse(input logic [29:0] vec);
        rx_vec = vec; rx_valid = 1'b1;
        @(negedge clk156);
        rx_valid = 1'b0; rx_vec = '0;
    endtask

    task automatic do_snap(output logic done);
        snap_req = 1'b1;
        @(negedge clk156);
        snap_req = 1'b0;
        done = snap_done;
        @(negedge clk156);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [47:0] d, output logic v);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk156);
        rd_en = 1'b0;
        d = rd_data; v = rd_valid;
    endtask

    task automatic test_reset();
        logic [47:0] d;
        logic        v;
        sys_rst_n = 1'b0;
        rx_vec = '0; rx_valid = 1'b0; tx_vec = '0; tx_valid = 1'b0;
        snap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        s_rx_vec = '0; s_rx_valid = 1'b0; s_tx_vec = '0; s_tx_valid = 1'b0;
        s_snap_req = 1'b0; s_rd_en = 1'b0; s_rd_addr = '0;
        repeat (3) @(negedge clk156);
        n_total++;
        if (snap_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 48'd0)
            $display("FAIL reset_outputs: got done=%b valid=%b data=%0d, want 0 0 0", snap_done, rd_valid, rd_data);
        else n_pass++;
        sys_rst_n = 1'b1;
        @(negedge clk156);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), d, v);
            n_total++;
            if (d !== 48'd0 || v !== 1'b1)
                $display("FAIL reset_rd%0d: got %0d valid %b, want 0 valid 1", i, d, v);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [47:0] exp_v [8] = '{48'd3, 48'd1, 48'd1, 48'd192, 48'd0, 48'd0, 48'd0, 48'd0};
        logic [47:0] d;
        logic        v, done;
        repeat (3) rx_pulse({10'd0, 15'd64, 5'b00001});
        rx_pulse({10'd0, 15'd64, 5'b00110});
        do_snap(done);
        n_total++;
        if (done !== 1'b1) $display("FAIL basic_snap_done: got %b, want 1", done);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), d, v);
            n_total++;
            if (d !== exp_v[i] || v !== 1'b1)
                $display("FAIL basic_rd%0d: got %0d valid %b, want %0d valid 1", i, d, v, exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_coincident();
        logic [47:0] d;
        logic        v, done;
        rx_vec = {10'd0, 15'd1518, 5'b00001}; rx_valid = 1'b1;
        snap_req = 1'b1; rd_en = 1'b1; rd_addr = 3'd0;
        @(negedge clk156);
        rx_valid = 1'b0; rx_vec = '0; snap_req = 1'b0; rd_en = 1'b0;
        n_total++;
        if (rd_data !== 48'd3 || snap_done !== 1'b1)
            $display("FAIL coin_read_in_capture: got data=%0d done=%b, want 3 1", rd_data, snap_done);
        else n_pass++;
        @(negedge clk156);
        do_read(3'd3, d, v);
        n_total++;
        if (d !== 48'd0) $display("FAIL coin_shadow_bytes: got %0d, want 0", d);
        else n_pass++;
        do_read(3'd0, d, v);
        n_total++;
        if (d !== 48'd0) $display("FAIL coin_shadow_good: got %0d, want 0", d);
        else n_pass++;
        do_snap(done);
        do_read(3'd3, d, v);
        n_total++;
        if (d !== 48'd1518) $display("FAIL coin_next_bytes: got %0d, want 1518", d);
        else n_pass++;
        do_read(3'd0, d, v);
        n_total++;
        if (d !== 48'd1) $display("FAIL coin_next_good: got %0d, want 1", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp_v [4] = '{48'd1, 48'd100, 48'd1, 48'd200};
        logic [2:0]  addr_v [4] = '{3'd0, 3'd3, 3'd4, 3'd5};
        logic        done;
        rx_vec = {10'd0, 15'd100, 5'b00001}; rx_valid = 1'b1;
        tx_vec = {6'd0, 15'd200, 5'b00001};  tx_valid = 1'b1;
        @(negedge clk156);
        rx_valid = 1'b0; tx_valid = 1'b0; rx_vec = '0; tx_vec = '0;
        do_snap(done);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = addr_v[i];
            @(negedge clk156);
            n_total++;
            if (rd_data !== exp_v[i] || rd_valid !== 1'b1)
                $display("FAIL b2b_rd%0d: got %0d valid %b, want %0d valid 1", addr_v[i], rd_data, rd_valid, exp_v[i]);
            else n_pass++;
        end
        rd_en = 1'b0;
        @(negedge clk156);
        n_total++;
        if (rd_data !== 48'd200 || rd_valid !== 1'b0)
            $display("FAIL b2b_hold: got %0d valid %b, want 200 valid 0", rd_data, rd_valid);
        else n_pass++;
    endtask

    task automatic test_bcast_mcast();
        logic [47:0] exp_v [8] = '{48'd2, 48'd1, 48'd0, 48'd120, 48'd0, 48'd0, 48'd1, 48'd1};
        logic [47:0] d;
        logic        v, done;
        rx_pulse({10'd0, 15'd60, 5'b01001});
        rx_pulse({10'd0, 15'd60, 5'b10010});
        rx_pulse({10'd0, 15'd60, 5'b10001});
        do_snap(done);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), d, v);
            n_total++;
            if (d !== exp_v[i])
                $display("FAIL cast_rd%0d: got %0d, want %0d", i, d, exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [47:0] exp_good;
`ifdef ETH_STATS_SATURATE_EN
        exp_good = 48'd3;
`else
        exp_good = 48'd1;
`endif
        s_rx_vec = {10'd0, 15'd0, 5'b00001};
        s_rx_valid = 1'b1;
        repeat (5) @(negedge clk156);
        s_rx_valid = 1'b0;
        s_snap_req = 1'b1;
        @(negedge clk156);
        s_snap_req = 1'b0;
        @(negedge clk156);
        s_rd_en = 1'b1; s_rd_addr = 3'd0;
        @(negedge clk156);
        s_rd_en = 1'b0;
        n_total++;
        if (s_rd_data !== exp_good || s_rd_valid !== 1'b1)
            $display("FAIL overflow_rd0: got %0d valid %b, want %0d valid 1", s_rd_data, s_rd_valid, exp_good);
        else n_pass++;
    endtask

    task automatic test_reset_in_done();
        logic [47:0] d;
        logic        v;
        logic        seen_done;
        rx_pulse({10'd0, 15'd10, 5'b00001});
        snap_req = 1'b1;
        @(posedge clk156);
        #1;
        sys_rst_n = 1'b0;
        #1;
        seen_done = snap_done;
        repeat (2) @(negedge clk156);
        sys_rst_n = 1'b1; snap_req = 1'b0;
        repeat (3) begin
            @(negedge clk156);
            seen_done = seen_done | snap_done;
        end
        n_total++;
        if (seen_done !== 1'b0) $display("FAIL rstdone_no_pulse: got %b, want 0", seen_done);
        else n_pass++;
        n_total++;
        if (rd_data !== 48'd0) $display("FAIL rstdone_rd_data: got %0d, want 0", rd_data);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), d, v);
            n_total++;
            if (d !== 48'd0) $display("FAIL rstdone_rd%0d: got %0d, want 0", i, d);
            else n_pass++;
        end
    endtask

    task automatic test_held_req();
        logic        exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [47:0] d;
        logic        v;
        snap_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk156);
            rx_valid = 1'b0; rx_vec = '0;
            if (i == 0) begin
                rx_vec = {10'd0, 15'd5, 5'b00001}; rx_valid = 1'b1;
            end
            if (i == 3) snap_req = 1'b0;
            n_total++;
            if (snap_done !== exp_d[i])
                $display("FAIL held_done_c%0d: got %b, want %b", i + 1, snap_done, exp_d[i]);
            else n_pass++;
        end
        do_read(3'd0, d, v);
        n_total++;
        if (d !== 48'd1) $display("FAIL held_rd0: got %0d, want 1", d);
        else n_pass++;
        do_read(3'd3, d, v);
        n_total++;
        if (d !== 48'd5) $display("FAIL held_rd3: got %0d, want 5", d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coincident();
        test_back_to_back();
        test_bcast_mcast();
        test_overflow();
        test_reset_in_done();
        test_held_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
